ugate_vector_checker: RTL and testbench
=======================================

# ugate_vector_checker

Self-checking stimulus/response stage for the NAND-built universal gate block. It drives the gate's `a`/`b` inputs through all four 2-bit vectors and samples its `y1` (AND), `y2` (OR) and `y3` (NOT a) outputs after a settle window. It compares each sample against the expected truth table, then reports a pass/fail verdict, an error count and first-failure diagnostics. It sits on both sides of the gate: its `a`/`b` outputs feed the gate, and its `y1`/`y2`/`y3` inputs consume the gate's outputs.

## Interface
Parameters:
- `SETTLE`, default 2: idle cycles between driving a vector and sampling it. Legal range is 0 or more.
- `PASSES`, default 1: number of full 4-vector sweeps per run. Must be 1 or more.
- `CNT_W`, default 8: width of the error counter.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: run request; sampled only in IDLE.
- `a`, `b`  output  1 each: registered stimulus to the gate.
- `y1`, `y2`, `y3`  input  1 each: gate outputs under test.
- `busy`  output  1: high from the cycle after `start` is accepted through the DONE cycle.
- `done`  output  1: one-cycle pulse at the end of a run.
- `pass`  output  1: verdict of the last run; updated at the DONE entry edge; held.
- `err_cnt`  output  CNT_W: number of failing vectors in the run; saturating.
- `fail_mask`  output  3: sticky per-output mismatch flags, {y3,y2,y1}.
- `first_fail_vec`  output  2: {a,b} of the first failing vector.
- `first_fail_valid`  output  1: `first_fail_vec` holds a recorded failure.

## Operation
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE. The state is held in registers.
- IDLE:
  - `a`=`b`=0 and `busy`=0. Result outputs hold their previous values.
  - `start`=1 does the following on one edge: clears `err_cnt`, `fail_mask`, `first_fail_*` and `pass`; sets vector index `vec`=0 and pass index `pidx`=0; sets {a,b}<=2'b00; moves to DRIVE.
- DRIVE: lasts 1 cycle. Goes to WAIT if `SETTLE`>0, else straight to SAMPLE.
- WAIT: lasts exactly `SETTLE` cycles, counted by a down-counter, then goes to SAMPLE.
- SAMPLE: lasts 1 cycle. On its closing edge:
  - Compute expected values: y1=a&b, y2=a|b, y3=~a.
  - Form per-bit mismatch m[2:0] and OR it into `fail_mask`.
  - If m≠0, increment `err_cnt` by 1 per vector, not per bit. The counter saturates at 2^CNT_W−1.
  - If m≠0 and `first_fail_valid`=0, latch `first_fail_vec`={a,b} and set `first_fail_valid`.
  - Advance:
    - If `vec`<3: `vec`+1, {a,b}<=new `vec`, go to DRIVE.
    - If `vec`=3 and `pidx`<PASSES−1: `pidx`+1, `vec`=0, {a,b}<=00, go to DRIVE.
    - Otherwise go to DONE and set `pass`=(no mismatch in the run, this sample included).
- DONE: lasts 1 cycle with `done`=1, `busy`=1 and {a,b}=00; then returns to IDLE.
- Vector order is 00, 01, 10, 11, where {a,b}=vec.
- `start` is ignored in every state other than IDLE, including DONE.
- Reset, asynchronous at any time including mid-run:
  - State goes to IDLE.
  - `a`, `b`, `busy`, `done`, `pass`, `err_cnt`, `fail_mask`, `first_fail_vec` and `first_fail_valid` all go to 0.
  - A run interrupted by reset is not resumed.

## Timing
- Reset values: every output is 0.
- Call the `start` acceptance edge edge 0; cycle k is the cycle after edge k−1.
- Each vector occupies SETTLE+2 cycles: DRIVE + WAIT + SAMPLE.
- Let N = 4·PASSES. Vectors occupy cycles 1 through N·(SETTLE+2).
- `done` is high in cycle N·(SETTLE+2)+1; with default parameters that is cycle 17.
- `busy` is high in cycles 1 through N·(SETTLE+2)+1. It is low in cycle 0 (the IDLE cycle in which `start` is sampled).
- `y*` are sampled at the end of the SAMPLE cycle, so `a`/`b` have been stable for SETTLE+2 cycles.
- `a`/`b` change only on SAMPLE closing edges, on the start-acceptance edge, and on reset.
- Earliest back-to-back restart: `start` accepted in the first IDLE cycle after DONE.

## Test plan
- Correct gate model (AND/OR/NOT), defaults, `start` pulsed once:
  - Result: `done` in cycle 17, `pass`=1, `err_cnt`=0, `fail_mask`=000, `first_fail_valid`=0.
  - `a`/`b` sequence is 00, 01, 10, 11, each held 4 cycles.
- y2 wired as NAND(a,b):
  - Mismatches at vectors 00 and 11.
  - Result: `err_cnt`=2, `fail_mask`=3'b010, `first_fail_vec`=00, `pass`=0.
- y3 stuck at 0:
  - Mismatches at vectors 00 and 01.
  - Result: `err_cnt`=2, `fail_mask`=3'b100, `first_fail_vec`=00, `pass`=0.
- All outputs inverted, PASSES=3, CNT_W=3, SETTLE=0:
  - 12 failing vectors; `err_cnt` saturates at 7; `fail_mask`=111.
  - `done` in cycle 25.
- `start` held high for a whole run:
  - `start` is ignored during the run and in the DONE cycle.
  - A new run is accepted in the following IDLE cycle, and all results clear on that edge.
- `rst_n` asserted in cycle 6 of a failing run:
  - All outputs go to 0 immediately, with no `done` pulse.
  - A subsequent `start` runs a full 17-cycle run.

Source files
------------

// File: rtl/ugate_vector_checker.sv
// ugate_vector_checker
// Stimulus/response checker for the NAND-built universal gate block. Walks
// {a,b} through 00, 01, 10, 11 (PASSES times). After each vector has settled,
// it compares the gate outputs against AND / OR / NOT-a. At the end of the
// run it reports a verdict, a saturating error count and first-failure data.
//
// Parameters:
//   SETTLE  idle cycles between driving a vector and sampling it (>= 0)
//   PASSES  number of full 4-vector sweeps per run (>= 1)
//   CNT_W   width of the error counter
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, honoured only in IDLE
//   a, b              registered stimulus to the gate
//   y1, y2, y3        gate outputs under test (AND, OR, NOT a)
//   busy              high from the cycle after start acceptance through DONE
//   done              one-cycle end-of-run pulse
//   pass              verdict of the last run (held)
//   err_cnt           failing vectors in the run, saturating
//   fail_mask         sticky per-output mismatch flags {y3,y2,y1}
//   first_fail_vec    {a,b} of the first failing vector
//   first_fail_valid  first_fail_vec holds a recorded failure
//   state_dbg         current FSM state (debug observation)
//
// Handshake: start is a level request sampled only while the FSM is in IDLE.
// Its acceptance is visible one cycle later as busy=1. The run completes with
// a single done pulse, and all result outputs are valid from that cycle until
// the next accepted start.

module ugate_vector_checker #(
   parameter int SETTLE = 2,
   parameter int PASSES = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic             y1,
   input  logic             y2,
   input  logic             y3,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [2:0]       fail_mask,
   output logic [1:0]       first_fail_vec,
   output logic             first_fail_valid,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // The wait counter only ever holds SETTLE-1 down to 0.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SW-1:0] WAIT_LOAD = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [PW-1:0] PIDX_LAST = PW'(PASSES - 1);

   state_t          state;
   logic [1:0]      vec;
   logic [PW-1:0]   pidx;
   logic [SW-1:0]   wait_cnt;
   logic [2:0]      expected;
   logic [2:0]      mism;

   // The stimulus is registered and held across WAIT, so the comparison is
   // made against the current a/b.
   always_comb begin
      expected = {~a, a | b, a & b};
      mism     = expected ^ {y3, y2, y1};
   end

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         vec              <= 2'd0;
         pidx             <= '0;
         wait_cnt         <= '0;
         a                <= 1'b0;
         b                <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_cnt          <= '0;
         fail_mask        <= 3'b000;
         first_fail_vec   <= 2'b00;
         first_fail_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_cnt          <= '0;
                  fail_mask        <= 3'b000;
                  first_fail_vec   <= 2'b00;
                  first_fail_valid <= 1'b0;
                  pass             <= 1'b0;
                  vec              <= 2'd0;
                  pidx             <= '0;
                  {a, b}           <= 2'b00;
                  busy             <= 1'b1;
                  state            <= S_DRIVE;
               end
            end

            S_DRIVE: begin
               if (SETTLE > 0) begin
                  wait_cnt <= WAIT_LOAD;
                  state    <= S_WAIT;
               end else begin
                  state <= S_SAMPLE;
               end
            end

            S_WAIT: begin
               if (wait_cnt == '0) state <= S_SAMPLE;
               else                wait_cnt <= wait_cnt - SW'(1);
            end

            S_SAMPLE: begin
               fail_mask <= fail_mask | mism;
               // One count per failing vector, however many outputs are wrong.
               if (mism != 3'b000) begin
                  if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                  if (!first_fail_valid) begin
                     first_fail_vec   <= {a, b};
                     first_fail_valid <= 1'b1;
                  end
               end
               if (vec != 2'd3) begin
                  vec    <= vec + 2'd1;
                  {a, b} <= vec + 2'd1;
                  state  <= S_DRIVE;
               end else if (pidx != PIDX_LAST) begin
                  pidx   <= pidx + PW'(1);
                  vec    <= 2'd0;
                  {a, b} <= 2'b00;
                  state  <= S_DRIVE;
               end else begin
                  {a, b} <= 2'b00;
                  // fail_mask does not yet include this sample, so merge it in.
                  pass   <= ((fail_mask | mism) == 3'b000);
                  done   <= 1'b1;
                  state  <= S_DONE;
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ugate_vector_checker.sv
`timescale 1ns/1ps
module tb_ugate_vector_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int asserts = 0;
   int fails   = 0;

   // Gate behaviour selector for dut0: 0 correct, 1 y2=NAND, 2 y3 stuck 0,
   // 3 all inverted, 4 random per-vector/per-output flips taken from flip0.
   int          gmode0 = 0;
   logic [11:0] flip0  = 12'h000;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;

   logic       a0, b0, y1_0, y2_0, y3_0, busy0, done0, pass0, ffv0;
   logic [7:0] err0;
   logic [2:0] mask0, st0;
   logic [1:0] ffvec0;

   logic       a1, b1, y1_1, y2_1, y3_1, busy1, done1, pass1, ffv1;
   logic [2:0] err1;
   logic [2:0] mask1, st1;
   logic [1:0] ffvec1;

   // Gate under test, returned as {y3,y2,y1}.
   function automatic logic [2:0] gate_out(input int mode, input logic [11:0] flip,
                                           input logic ga, input logic gb);
      logic [2:0] good;
      int idx;
      good = {~ga, ga | gb, ga & gb};
      idx  = int'({ga, gb}) * 3;
      case (mode)
         0:       return good;
         1:       return {good[2], ~(ga & gb), good[0]};
         2:       return {1'b0, good[1:0]};
         3:       return ~good;
         default: return good ^ flip[idx +: 3];
      endcase
   endfunction

   assign {y3_0, y2_0, y1_0} = gate_out(gmode0, flip0, a0, b0);
   assign {y3_1, y2_1, y1_1} = gate_out(3, 12'h000, a1, b1);

   ugate_vector_checker #(.SETTLE(2), .PASSES(1), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
      .y1(y1_0), .y2(y2_0), .y3(y3_0), .busy(busy0), .done(done0),
      .pass(pass0), .err_cnt(err0), .fail_mask(mask0),
      .first_fail_vec(ffvec0), .first_fail_valid(ffv0), .state_dbg(st0)
   );

   ugate_vector_checker #(.SETTLE(0), .PASSES(3), .CNT_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .y1(y1_1), .y2(y2_1), .y3(y3_1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err1), .fail_mask(mask1),
      .first_fail_vec(ffvec1), .first_fail_valid(ffv1), .state_dbg(st1)
   );

   // Reference: apply the truth table to every vector of every sweep.
   task automatic ref_model(input int mode, input logic [11:0] flip, input int passes,
                            input int cnt_w, output int exp_err, output logic [2:0] exp_mask,
                            output logic exp_ffv, output logic [1:0] exp_ffvec,
                            output logic exp_pass);
      int nfail;
      logic [1:0] vv;
      logic [2:0] truth, m;
      nfail = 0;
      exp_mask = 3'b000;
      exp_ffv = 1'b0;
      exp_ffvec = 2'b00;
      for (int p = 0; p < passes; p++) begin
         for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            truth = {~vv[1], vv[1] | vv[0], vv[1] & vv[0]};
            m = truth ^ gate_out(mode, flip, vv[1], vv[0]);
            if (m != 3'b000) begin
               nfail++;
               exp_mask = exp_mask | m;
               if (!exp_ffv) begin
                  exp_ffv = 1'b1;
                  exp_ffvec = vv;
               end
            end
         end
      end
      exp_err  = (nfail > (1 << cnt_w) - 1) ? (1 << cnt_w) - 1 : nfail;
      exp_pass = (nfail == 0);
   endtask

   // Full run on dut0 (SETTLE=2, PASSES=1): 16 vector cycles, done in cycle 17,
   // then one IDLE cycle. skip=1 means start is already high from the previous
   // run, so the next edge is the acceptance edge.
   task automatic run_check(input string name, input int mode, input bit hold, input bit skip);
      int total, done_cyc, exp_err;
      logic [2:0] exp_mask;
      logic exp_ffv, exp_pass;
      logic [1:0] exp_ffvec, exp_ab;
      logic [3:0] exp_ctl, got_ctl;
      logic [14:0] exp_res, got_res;
      total = 4 * (2 + 2);
      done_cyc = total + 1;
      gmode0 = mode;
      ref_model(mode, flip0, 1, 8, exp_err, exp_mask, exp_ffv, exp_ffvec, exp_pass);
      exp_res = {exp_pass, 8'(exp_err), exp_mask, exp_ffv, exp_ffvec};
      if (!skip) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1 start0 = 1'b1;
      end
      @(posedge clk);
      #1 start0 = hold;
      for (int k = 1; k <= done_cyc + 1; k++) begin
         @(negedge clk);
         exp_ab  = (k <= total) ? 2'(((k - 1) / 4) % 4) : 2'b00;
         exp_ctl = {k <= done_cyc, k == done_cyc, exp_ab};
         got_ctl = {busy0, done0, a0, b0};
         asserts++;
         if (got_ctl !== exp_ctl) begin
            fails++;
            $display("FAIL %s busy/done/a/b cycle=%0d got=%b exp=%b", name, k, got_ctl, exp_ctl);
         end
         got_res = {pass0, err0, mask0, ffv0, ffvec0};
         if (k == 1) begin
            asserts++;
            if (got_res !== 15'd0) begin
               fails++;
               $display("FAIL %s results_cleared got=%h exp=0", name, got_res);
            end
         end
         if (k >= done_cyc) begin
            asserts++;
            if (got_res !== exp_res) begin
               fails++;
               $display("FAIL %s results cycle=%0d got=%h exp=%h", name, k, got_res, exp_res);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      asserts++;
      if ({a0, b0, busy0, done0, pass0, err0, mask0, ffv0, ffvec0} !== 19'd0) begin
         fails++;
         $display("FAIL reset_dut0 got=%h exp=0", {a0, b0, busy0, done0, pass0, err0, mask0, ffv0, ffvec0});
      end
      asserts++;
      if ({a1, b1, busy1, done1, pass1, err1, mask1, ffv1, ffvec1} !== 14'd0) begin
         fails++;
         $display("FAIL reset_dut1 got=%h exp=0", {a1, b1, busy1, done1, pass1, err1, mask1, ffv1, ffvec1});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_correct_gate;
      run_check("correct_gate", 0, 1'b0, 1'b0);
   endtask

   task automatic test_y2_nand;
      run_check("y2_nand", 1, 1'b0, 1'b0);
   endtask

   task automatic test_y3_stuck0;
      run_check("y3_stuck0", 2, 1'b0, 1'b0);
   endtask

   // dut1: SETTLE=0, PASSES=3, CNT_W=3 with every output inverted.
   task automatic test_saturation;
      int total, done_cyc, exp_err;
      logic [2:0] exp_mask;
      logic exp_ffv, exp_pass;
      logic [1:0] exp_ffvec, exp_ab;
      logic [3:0] exp_ctl, got_ctl;
      logic [9:0] exp_res, got_res;
      total = 12 * 2;
      done_cyc = total + 1;
      ref_model(3, 12'h000, 3, 3, exp_err, exp_mask, exp_ffv, exp_ffvec, exp_pass);
      exp_res = {exp_pass, 3'(exp_err), exp_mask, exp_ffv, exp_ffvec};
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int k = 1; k <= done_cyc + 1; k++) begin
         @(negedge clk);
         exp_ab  = (k <= total) ? 2'(((k - 1) / 2) % 4) : 2'b00;
         exp_ctl = {k <= done_cyc, k == done_cyc, exp_ab};
         got_ctl = {busy1, done1, a1, b1};
         asserts++;
         if (got_ctl !== exp_ctl) begin
            fails++;
            $display("FAIL saturation busy/done/a/b cycle=%0d got=%b exp=%b", k, got_ctl, exp_ctl);
         end
         if (k == done_cyc) begin
            got_res = {pass1, err1, mask1, ffv1, ffvec1};
            asserts++;
            if (got_res !== exp_res) begin
               fails++;
               $display("FAIL saturation results got=%h exp=%h", got_res, exp_res);
            end
         end
      end
   endtask

   task automatic test_start_held;
      run_check("start_held", 3, 1'b1, 1'b0);
      run_check("restart_after_held", 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_run;
      gmode0 = 2;
      @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk);              // edge 0
      #1 start0 = 1'b0;
      repeat (4) @(posedge clk);   // edge 4: vector 00 sampled, it fails
      #1;
      asserts++;
      if ({busy0, err0, ffv0} !== {1'b1, 8'd1, 1'b1}) begin
         fails++;
         $display("FAIL pre_reset_progress got=%h exp=%h", {busy0, err0, ffv0}, {1'b1, 8'd1, 1'b1});
      end
      @(posedge clk);              // edge 5, now in cycle 6
      #2 rst_n = 1'b0;
      #1;
      asserts++;
      if ({a0, b0, busy0, done0, pass0, err0, mask0, ffv0, ffvec0} !== 19'd0) begin
         fails++;
         $display("FAIL mid_run_reset got=%h exp=0", {a0, b0, busy0, done0, pass0, err0, mask0, ffv0, ffvec0});
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         asserts++;
         if (done0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done got=%b exp=0", done0);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_check("after_reset", 0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      int mode;
      for (int i = 0; i < 6; i++) begin
         mode  = $urandom_range(0, 4);
         flip0 = 12'($urandom);
         run_check($sformatf("random%0d_mode%0d", i, mode), mode, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      fails++;
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_correct_gate();
      test_y2_nand();
      test_y3_stuck0();
      test_saturation();
      test_start_held();
      test_reset_mid_run();
      test_random();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
